// File: rtl/build_id_led_seq.sv
// Serial LED readout of the three build-ID word pairs (scripts, top, common),
// one nibble per tick rising edge, with header and gap phases between nibbles.
module build_id_led_seq #(
  parameter int HDR_TICKS = 4
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        tick_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        loop_i,
  input  logic [63:0] git_hash_scripts_i,
  input  logic [31:0] timestamp_scripts_i,
  input  logic [63:0] git_hash_top_i,
  input  logic [31:0] timestamp_top_i,
  input  logic [63:0] git_hash_common_i,
  input  logic [31:0] timestamp_common_i,
  output logic [2:0]  src_o,
  output logic [3:0]  nib_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, HDR, SHOW, GAP} state_t;

  state_t          state, state_n;
  logic            tick_q, tick_edge;
  logic [3:0]      hdr_cnt, hdr_n;
  logic [4:0]      nib_idx, nib_n;
  logic [1:0]      src_idx, srci_n;
  logic            snap, done_n;
  logic [2:0][63:0] sh_gh, gh_n;
  logic [2:0][31:0] sh_ts, ts_n;
  logic [63:0]     g_sel;
  logic [31:0]     t_sel;
  logic [3:0]      nib_out_n;
  logic [2:0]      src_out_n;

  assign tick_edge = tick_i & ~tick_q;

  always_comb begin
    state_n = state;
    hdr_n   = hdr_cnt;
    nib_n   = nib_idx;
    srci_n  = src_idx;
    snap    = 1'b0;
    done_n  = 1'b0;
    if (stop_i) begin
      state_n = IDLE;
      hdr_n   = '0;
      nib_n   = '0;
      srci_n  = '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          snap    = 1'b1;
          state_n = HDR;
          hdr_n   = '0;
          nib_n   = '0;
          srci_n  = '0;
        end
        HDR: if (tick_edge) begin
          if (hdr_cnt == 4'(HDR_TICKS - 1)) begin
            state_n = SHOW;
            hdr_n   = '0;
            nib_n   = '0;
          end else begin
            hdr_n = hdr_cnt + 4'd1;
          end
        end
        SHOW: if (tick_edge) state_n = GAP;
        GAP: if (tick_edge) begin
          if (nib_idx != 5'd23) begin
            nib_n   = nib_idx + 5'd1;
            state_n = SHOW;
          end else if (src_idx != 2'd2) begin
            srci_n  = src_idx + 2'd1;
            hdr_n   = '0;
            nib_n   = '0;
            state_n = HDR;
          end else if (loop_i) begin
            snap    = 1'b1;
            srci_n  = '0;
            hdr_n   = '0;
            nib_n   = '0;
            state_n = HDR;
          end else begin
            done_n  = 1'b1;
            srci_n  = '0;
            nib_n   = '0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    gh_n = snap ? {git_hash_common_i, git_hash_top_i, git_hash_scripts_i} : sh_gh;
    ts_n = snap ? {timestamp_common_i, timestamp_top_i, timestamp_scripts_i} : sh_ts;

    case (srci_n)
      2'd1:    begin g_sel = gh_n[1]; t_sel = ts_n[1]; end
      2'd2:    begin g_sel = gh_n[2]; t_sel = ts_n[2]; end
      default: begin g_sel = gh_n[0]; t_sel = ts_n[0]; end
    endcase

    // Outputs are computed from next-state values so the registers change on the advancing edge
    src_out_n = '0;
    if (state_n == HDR || state_n == SHOW) src_out_n = 3'b001 << srci_n;
    nib_out_n = '0;
    if (state_n == SHOW) begin
      if (!nib_n[4]) nib_out_n = g_sel[{4'd15 - nib_n[3:0], 2'b00} +: 4];
      else           nib_out_n = t_sel[{3'd7 - nib_n[2:0], 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state   <= IDLE;
      tick_q  <= 1'b0;
      hdr_cnt <= '0;
      nib_idx <= '0;
      src_idx <= '0;
      sh_gh   <= '0;
      sh_ts   <= '0;
      src_o   <= '0;
      nib_o   <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_n;
      tick_q  <= tick_i;
      hdr_cnt <= hdr_n;
      nib_idx <= nib_n;
      src_idx <= srci_n;
      sh_gh   <= gh_n;
      sh_ts   <= ts_n;
      src_o   <= src_out_n;
      nib_o   <= nib_out_n;
      valid_o <= (state_n == SHOW);
      busy_o  <= (state_n != IDLE);
      done_o  <= done_n;
    end
  end

endmodule

// File: tb/tb_build_id_led_seq.sv
// Randomized self-checking bench for build_id_led_seq against a position-based
// model of the readout sequence.
module tb_build_id_led_seq;
  localparam int H   = 4;
  localparam int L   = H + 48;
  localparam int RUN = 3 * L;

  logic clk100 = 0, rst = 1, tick = 0, start = 0, stop = 0, loop_en = 0;
  logic [63:0] gh [3];
  logic [31:0] ts [3];
  logic [2:0] src_o;
  logic [3:0] nib_o;
  logic valid_o, busy_o, done_o;
  logic [95:0] w [3];
  int errs = 0, checks = 0;

  always #5 clk100 = ~clk100;

  build_id_led_seq #(.HDR_TICKS(H)) dut (
    .clk100(clk100), .rst(rst), .tick_i(tick), .start_i(start), .stop_i(stop),
    .loop_i(loop_en),
    .git_hash_scripts_i(gh[0]), .timestamp_scripts_i(ts[0]),
    .git_hash_top_i(gh[1]),     .timestamp_top_i(ts[1]),
    .git_hash_common_i(gh[2]),  .timestamp_common_i(ts[2]),
    .src_o(src_o), .nib_o(nib_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  wire [9:0] obs = {src_o, nib_o, valid_o, busy_o, done_o};

  // Expected {src,nib,valid,busy,done} after p tick edges since start
  function automatic logic [9:0] exp_at(int p);
    int s, o, q;
    logic [95:0] sh;
    if (p >= RUN) return 10'b1;
    s = p / L;
    o = p % L;
    if (o < H) return {3'(1 << s), 4'h0, 1'b0, 1'b1, 1'b0};
    q = o - H;
    if (q % 2 == 1) return {3'b000, 4'h0, 1'b0, 1'b1, 1'b0};
    sh = w[s] >> (4 * (23 - q / 2));
    return {3'(1 << s), sh[3:0], 1'b1, 1'b1, 1'b0};
  endfunction

  task automatic step();
    @(negedge clk100) tick = 1;
    @(negedge clk100) tick = 0;
  endtask

  task automatic load_snap();
    for (int i = 0; i < 3; i++) w[i] = {gh[i], ts[i]};
  endtask

  task automatic do_start();
    @(negedge clk100) start = 1;
    load_snap();
    @(negedge clk100) start = 0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 3; i++) begin
      gh[i] = {$urandom, $urandom};
      ts[i] = $urandom;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk100);
    checks++;
    if (obs !== 10'b0) begin errs++; $display("FAIL reset_hold got=%h exp=000", obs); end
    rst = 0;
    @(negedge clk100);
    checks++;
    if (obs !== 10'b0) begin errs++; $display("FAIL reset_release got=%h exp=000", obs); end
  endtask

  task automatic run_checked(string name, int from, int to);
    for (int p = from; p <= to; p++) begin
      if (p > 0) step();
      checks++;
      if (obs !== exp_at(p)) begin
        errs++;
        $display("FAIL %s p=%0d got=%h exp=%h", name, p, obs, exp_at(p));
      end
    end
  endtask

  task automatic check_idle(string name);
    @(negedge clk100);
    checks++;
    if (obs !== 10'b0) begin errs++; $display("FAIL %s got=%h exp=000", name, obs); end
  endtask

  task automatic test_basic();
    gh[0] = 64'h0123_4567_89AB_CDEF; ts[0] = 32'h6655_4433;
    gh[1] = 64'hFEDC_BA98_7654_3210; ts[1] = 32'h1122_3344;
    gh[2] = 64'hA5A5_5A5A_C3C3_3C3C; ts[2] = 32'hDEAD_BEEF;
    do_start();
    run_checked("basic", 0, RUN);
    check_idle("basic_done_pulse_ends");
  endtask

  task automatic test_tick_high();
    rand_inputs();
    @(negedge clk100) tick = 1;
    do_start();
    repeat (50) @(negedge clk100);
    checks++;
    if (obs !== exp_at(0)) begin errs++; $display("FAIL tick_high_at_start got=%h exp=%h", obs, exp_at(0)); end
    tick = 0;
    @(negedge clk100) tick = 1;
    repeat (50) @(negedge clk100);
    checks++;
    if (obs !== exp_at(1)) begin errs++; $display("FAIL tick_held got=%h exp=%h", obs, exp_at(1)); end
    tick = 0;
    @(negedge clk100);
    run_checked("tick_relaunch", 2, 2);
    @(negedge clk100) stop = 1;
    @(negedge clk100) stop = 0;
  endtask

  task automatic test_mid_change();
    rand_inputs();
    do_start();
    run_checked("mid_a", 0, 10);
    gh[1] = '1;
    ts[1] = ~ts[1];
    run_checked("mid_b", 11, RUN);
    check_idle("mid_done_pulse_ends");
  endtask

  task automatic test_abort();
    rand_inputs();
    do_start();
    run_checked("abort_pre", 0, H + 14);
    @(negedge clk100) stop = 1;
    @(negedge clk100) stop = 0;
    checks++;
    if (obs !== 10'b0) begin errs++; $display("FAIL abort got=%h exp=000", obs); end
    step();
    checks++;
    if (obs !== 10'b0) begin errs++; $display("FAIL abort_no_done got=%h exp=000", obs); end
    @(negedge clk100) begin start = 1; stop = 1; end
    @(negedge clk100) begin start = 0; stop = 0; end
    checks++;
    if (busy_o !== 1'b0) begin errs++; $display("FAIL start_stop_collide busy=%b exp=0", busy_o); end
    step();
    checks++;
    if (obs !== 10'b0) begin errs++; $display("FAIL collide_idle got=%h exp=000", obs); end
  endtask

  task automatic test_loop();
    rand_inputs();
    do_start();
    run_checked("loop_a", 0, RUN - 1);
    loop_en = 1;
    rand_inputs();
    load_snap();
    step();
    checks++;
    if (obs !== exp_at(0)) begin errs++; $display("FAIL loop_reenter got=%h exp=%h", obs, exp_at(0)); end
    loop_en = 0;
    run_checked("loop_b", 1, RUN);
    check_idle("loop_done_pulse_ends");
  endtask

  task automatic test_reset_busy();
    rand_inputs();
    do_start();
    run_checked("rst_pre", 0, 80);
    @(negedge clk100) rst = 1;
    @(negedge clk100) rst = 0;
    checks++;
    if (obs !== 10'b0) begin errs++; $display("FAIL rst_midrun got=%h exp=000", obs); end
    rand_inputs();
    do_start();
    run_checked("rst_restart", 0, H + 3);
    @(negedge clk100) start = 1;
    rand_inputs();
    @(negedge clk100) start = 0;
    checks++;
    if (obs !== exp_at(H + 3)) begin errs++; $display("FAIL start_busy got=%h exp=%h", obs, exp_at(H + 3)); end
    run_checked("rst_rest", H + 4, RUN);
    check_idle("rst_done_pulse_ends");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin gh[i] = '0; ts[i] = '0; end
    test_reset();
    test_basic();
    test_tick_high();
    test_mid_change();
    test_abort();
    test_loop();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
